// File: rtl/leb128_fetch.sv
// leb128_fetch: fetches up to 10 bytes from a byte ROM in one multi-byte read,
// then decodes a WebAssembly LEB128 integer (signed/unsigned, 32/64 bit),
// one byte per cycle. Returns value, byte length and next address.
// Optional macro LEB128_STRICT_EN: reject unused non-zero/non-sign bits in
// the final byte of a full-length encoding.
module leb128_fetch #(
  parameter int AW    = 16,
  parameter int EXTRA = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [AW-1:0]             addr,
  input  logic                      is_signed,
  input  logic                      is_64,
  output logic                      busy,
  output logic [AW-1:0]             rom_addr,
  output logic [EXTRA-1:0]          rom_extra,
  input  logic [(2**EXTRA)*8-1:0]   rom_data,
  output logic                      done,
  output logic [63:0]               value,
  output logic [3:0]                len,
  output logic [AW-1:0]             next_addr,
  output logic                      error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_reg;
  logic [AW-1:0]    addr_reg;
  logic             sgn_reg;
  logic             w64_reg;
  logic [9:0][7:0]  buf_reg;
  logic [63:0]      acc_reg;
  logic [6:0]       shift_reg;
  logic [3:0]       idx_reg;
  logic [3:0]       res_len_reg;
  logic             res_err_reg;

  // ROM lanes: bytes are right-aligned, first byte most significant, so the
  // lane position of byte k depends on how many bytes were requested.
  logic [9:0][7:0]  lane;
  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_lane
      if (gi < 5) begin : g_low
        assign lane[gi] = w64_reg ? rom_data[8*(9-gi) +: 8] : rom_data[8*(4-gi) +: 8];
      end else begin : g_high
        assign lane[gi] = w64_reg ? rom_data[8*(9-gi) +: 8] : 8'h00;
      end
    end
  endgenerate

  logic [7:0]  cur_byte;
  logic [3:0]  last_idx;
  logic [6:0]  next_shift;
  logic [63:0] acc_or;
  logic [63:0] acc_term;
  logic        strict_bad;

  // Per-byte accumulate and optional sign fill for a terminating byte
  always_comb begin
    cur_byte   = buf_reg[idx_reg];
    last_idx   = w64_reg ? 4'd9 : 4'd4;
    next_shift = shift_reg + 7'd7;
    acc_or     = acc_reg | ({57'd0, cur_byte[6:0]} << shift_reg);
    acc_term   = acc_or;
    if (sgn_reg && (next_shift < 7'd64) && cur_byte[6])
      acc_term = acc_or | (~64'd0 << next_shift);
  end

`ifdef LEB128_STRICT_EN
  // Final byte of a full-length encoding may carry only meaningful bits
  always_comb begin
    strict_bad = 1'b0;
    if (idx_reg == last_idx) begin
      case ({w64_reg, sgn_reg})
        2'b00:   strict_bad = (cur_byte[6:4] != 3'b000);
        2'b01:   strict_bad = !((cur_byte[6:3] == 4'b0000) || (cur_byte[6:3] == 4'b1111));
        2'b10:   strict_bad = (cur_byte[6:1] != 6'd0);
        default: strict_bad = !((cur_byte[6:0] == 7'd0) || (cur_byte[6:0] == 7'h7f));
      endcase
    end
  end
`else
  assign strict_bad = 1'b0;
`endif

  // Trim a raw accumulator to the target width (sign- or zero-extend 32-bit)
  function automatic logic [63:0] fit_width(input logic [63:0] a, input logic w64, input logic sgn);
    if (w64)      return a;
    else if (sgn) return {{32{a[31]}}, a[31:0]};
    else          return {32'd0, a[31:0]};
  endfunction

  assign busy = (state_reg != S_IDLE);

  // Main FSM: fetch, load, decode byte by byte, publish results with done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      addr_reg    <= '0;
      sgn_reg     <= 1'b0;
      w64_reg     <= 1'b0;
      buf_reg     <= '0;
      acc_reg     <= '0;
      shift_reg   <= '0;
      idx_reg     <= '0;
      res_len_reg <= '0;
      res_err_reg <= 1'b0;
      rom_addr    <= '0;
      rom_extra   <= '0;
      done        <= 1'b0;
      value       <= '0;
      len         <= '0;
      next_addr   <= '0;
      error       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            addr_reg  <= addr;
            sgn_reg   <= is_signed;
            w64_reg   <= is_64;
            rom_addr  <= addr;
            rom_extra <= is_64 ? EXTRA'(9) : EXTRA'(4);
            state_reg <= S_FETCH;
          end
        end
        S_FETCH: state_reg <= S_LOAD;
        S_LOAD: begin
          buf_reg   <= lane;
          acc_reg   <= '0;
          shift_reg <= '0;
          idx_reg   <= '0;
          state_reg <= S_DECODE;
        end
        S_DECODE: begin
          if (!cur_byte[7]) begin
            acc_reg     <= fit_width(acc_term, w64_reg, sgn_reg);
            res_len_reg <= idx_reg + 4'd1;
            res_err_reg <= strict_bad;
            state_reg   <= S_DONE;
          end else if (idx_reg == last_idx) begin
            acc_reg     <= fit_width(acc_or, w64_reg, sgn_reg);
            res_len_reg <= last_idx + 4'd1;
            res_err_reg <= 1'b1;
            state_reg   <= S_DONE;
          end else begin
            acc_reg   <= acc_or;
            shift_reg <= next_shift;
            idx_reg   <= idx_reg + 4'd1;
          end
        end
        S_DONE: begin
          value     <= acc_reg;
          len       <= res_len_reg;
          next_addr <= addr_reg + AW'(res_len_reg);
          error     <= res_err_reg;
          done      <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leb128_fetch.sv
// Directed bench for leb128_fetch: a behavioural ROM with one-cycle read
// latency feeds two instances (AW=16 and AW=5 for address wrap).
module tb_leb128_fetch;

`ifdef LEB128_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // AW=16 instance
  logic         start = 1'b0, is_signed = 1'b0, is_64 = 1'b0;
  logic [15:0]  addr = '0;
  logic         busy, done, error;
  logic [15:0]  rom_addr, next_addr;
  logic [3:0]   rom_extra, len;
  logic [127:0] rom_data = '0;
  logic [63:0]  value;

  // AW=5 instance
  logic         start5 = 1'b0;
  logic [4:0]   addr5 = '0;
  logic         busy5, done5, error5;
  logic [4:0]   rom_addr5, next_addr5;
  logic [3:0]   rom_extra5, len5;
  logic [127:0] rom_data5 = '0;
  logic [63:0]  value5;

  bit [7:0] mem16 [0:65535];
  bit [7:0] mem5  [0:31];

  leb128_fetch #(.AW(16), .EXTRA(4)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .is_signed(is_signed),
    .is_64(is_64), .busy(busy), .rom_addr(rom_addr), .rom_extra(rom_extra),
    .rom_data(rom_data), .done(done), .value(value), .len(len),
    .next_addr(next_addr), .error(error)
  );

  leb128_fetch #(.AW(5), .EXTRA(4)) dut5 (
    .clk(clk), .reset(reset), .start(start5), .addr(addr5), .is_signed(1'b0),
    .is_64(1'b0), .busy(busy5), .rom_addr(rom_addr5), .rom_extra(rom_extra5),
    .rom_data(rom_data5), .done(done5), .value(value5), .len(len5),
    .next_addr(next_addr5), .error(error5)
  );

  function automatic logic [127:0] rom16(input logic [15:0] a, input logic [3:0] ex);
    logic [127:0] d = '0;
    for (int j = 0; j < 16; j++)
      if (j <= int'(ex)) d[8*(int'(ex)-j) +: 8] = mem16[16'(int'(a) + j)];
    return d;
  endfunction

  function automatic logic [127:0] rom5(input logic [4:0] a, input logic [3:0] ex);
    logic [127:0] d = '0;
    for (int j = 0; j < 16; j++)
      if (j <= int'(ex)) d[8*(int'(ex)-j) +: 8] = mem5[5'(int'(a) + j)];
    return d;
  endfunction

  // Byte ROM with one-cycle registered read
  always @(posedge clk) begin
    rom_data  <= rom16(rom_addr, rom_extra);
    rom_data5 <= rom5(rom_addr5, rom_extra5);
  end

  task automatic test_reset();
    #2;
    compared++;
    if (busy !== 1'b0 || done !== 1'b0 || value !== 64'd0 || len !== 4'd0 ||
        next_addr !== 16'd0 || error !== 1'b0 || rom_addr !== 16'd0 || rom_extra !== 4'd0) begin
      mismatched++;
      $display("FAIL reset_state: got busy=%b done=%b value=%h len=%0d next=%h err=%b raddr=%h rext=%0d want all zero",
               busy, done, value, len, next_addr, error, rom_addr, rom_extra);
    end
    @(negedge clk); reset = 1'b0;
    $display("reset: checked outputs cleared");
  endtask

  // One complete operation: ROM port, latency, results, single-cycle done
  task automatic run_op(input string name, input logic [15:0] a, input logic s, input logic w,
                        input logic [63:0] ev, input logic [3:0] el, input logic [15:0] ena,
                        input logic ee);
    int lat = 0;
    @(negedge clk); addr = a; is_signed = s; is_64 = w; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    compared++;
    if (rom_addr !== a || rom_extra !== (w ? 4'd9 : 4'd4)) begin
      mismatched++;
      $display("FAIL %s rom_port: got addr=%h extra=%0d want addr=%h extra=%0d",
               name, rom_addr, rom_extra, a, (w ? 9 : 4));
    end
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (done) lat = k;
    end
    compared++;
    if (lat != int'(el) + 3) begin
      mismatched++;
      $display("FAIL %s latency: got %0d want %0d (0 = timeout)", name, lat, int'(el) + 3);
    end
    compared++;
    if (value !== ev || len !== el || next_addr !== ena || error !== ee) begin
      mismatched++;
      $display("FAIL %s result: got value=%h len=%0d next=%h err=%b want value=%h len=%0d next=%h err=%b",
               name, value, len, next_addr, error, ev, el, ena, ee);
    end
    @(posedge clk); #1;
    compared++;
    if (done !== 1'b0) begin
      mismatched++;
      $display("FAIL %s done_width: got done=%b want 0", name, done);
    end
    $display("op %s: addr=%h value=%h len=%0d next=%h err=%b latency=%0d", name, a, value, len, next_addr, error, lat);
  endtask

  task automatic test_basic();
    run_op("u32_624485", 16'h0010, 1'b0, 1'b0, 64'h0000_0000_0009_8765, 4'd3, 16'h0013, 1'b0);
    run_op("s32_neg123456", 16'h0020, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 16'h0023, 1'b0);
    run_op("s32_7f", 16'h0030, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 16'h0031, 1'b0);
    run_op("u32_7f", 16'h0030, 1'b0, 1'b0, 64'h0000_0000_0000_007F, 4'd1, 16'h0031, 1'b0);
    run_op("s64_7f", 16'h0030, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 16'h0031, 1'b0);
  endtask

  task automatic test_errors();
    run_op("u32_noterm", 16'h0040, 1'b0, 1'b0, 64'd0, 4'd5, 16'h0045, 1'b1);
    run_op("u64_noterm", 16'h0050, 1'b0, 1'b1, 64'd0, 4'd10, 16'h005A, 1'b1);
  endtask

  task automatic test_full_length();
    run_op("u32_ff_1f", 16'h0060, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 4'd5, 16'h0065, STRICT);
    run_op("u32_ff_0f", 16'h0070, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 4'd5, 16'h0075, 1'b0);
    run_op("u64_max", 16'h0090, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 16'h009A, 1'b0);
  endtask

  task automatic test_wrap();
    int lat = 0;
    @(negedge clk); addr5 = 5'd30; start5 = 1'b1;
    @(posedge clk); #1 start5 = 1'b0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (done5) lat = k;
    end
    compared++;
    if (lat != 6 || value5 !== 64'h4081 || len5 !== 4'd3 || next_addr5 !== 5'd1 || error5 !== 1'b0) begin
      mismatched++;
      $display("FAIL wrap: got lat=%0d value=%h len=%0d next=%0d err=%b want lat=6 value=4081 len=3 next=1 err=0",
               lat, value5, len5, next_addr5, error5);
    end
    $display("op wrap: value=%h len=%0d next=%0d latency=%0d", value5, len5, next_addr5, lat);
  endtask

  task automatic test_abort();
    int dones = 0;
    @(negedge clk); addr = 16'h0050; is_signed = 1'b0; is_64 = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    compared++;
    if (busy !== 1'b0 || done !== 1'b0 || value !== 64'd0 || rom_addr !== 16'd0) begin
      mismatched++;
      $display("FAIL abort_reset: got busy=%b done=%b value=%h raddr=%h want 0 0 0 0", busy, done, value, rom_addr);
    end
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    compared++;
    if (dones != 0) begin
      mismatched++;
      $display("FAIL abort_no_done: got %0d done pulses want 0", dones);
    end
    $display("op abort: busy=%b after reset, done pulses=%0d", busy, dones);
    run_op("after_abort", 16'h0010, 1'b0, 1'b0, 64'h0000_0000_0009_8765, 4'd3, 16'h0013, 1'b0);
  endtask

  task automatic test_ignore_busy();
    int dones = 0;
    @(negedge clk); addr = 16'h0010; is_signed = 1'b0; is_64 = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (k == 2) begin addr = 16'h0020; is_signed = 1'b1; start = 1'b1; end
      if (k == 6) start = 1'b0;
    end
    compared++;
    if (dones != 1 || busy !== 1'b0 || value !== 64'h0009_8765) begin
      mismatched++;
      $display("FAIL ignore_busy: got dones=%0d busy=%b value=%h want dones=1 busy=0 value=98765", dones, busy, value);
    end
    $display("op ignore_busy: dones=%0d value=%h", dones, value);
  endtask

  task automatic test_back_to_back();
    int cyc [$];
    int bad_val = 0;
    @(negedge clk); addr = 16'h0010; is_signed = 1'b0; is_64 = 1'b0; start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done) begin
        cyc.push_back(c);
        if (value !== 64'h0009_8765) bad_val++;
      end
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    compared++;
    if (cyc.size() != 4 || bad_val != 0) begin
      mismatched++;
      $display("FAIL b2b_count: got %0d dones (%0d bad values) want 4 dones, 0 bad", cyc.size(), bad_val);
    end else begin
      compared++;
      if (cyc[0] != 6 || cyc[1] - cyc[0] != 7 || cyc[2] - cyc[1] != 7 || cyc[3] - cyc[2] != 7) begin
        mismatched++;
        $display("FAIL b2b_spacing: got cycles %0d %0d %0d %0d want 6 13 20 27", cyc[0], cyc[1], cyc[2], cyc[3]);
      end
    end
    $display("op back_to_back: %0d done pulses", cyc.size());
  endtask

  initial begin
    mem16[16'h10] = 8'hE5; mem16[16'h11] = 8'h8E; mem16[16'h12] = 8'h26;
    mem16[16'h20] = 8'hC0; mem16[16'h21] = 8'hBB; mem16[16'h22] = 8'h78;
    mem16[16'h30] = 8'h7F;
    for (int i = 0; i < 5; i++)  mem16[16'h40 + i] = 8'h80;
    for (int i = 0; i < 10; i++) mem16[16'h50 + i] = 8'h80;
    mem16[16'h5A] = 8'h00;
    for (int i = 0; i < 4; i++) begin mem16[16'h60 + i] = 8'hFF; mem16[16'h70 + i] = 8'hFF; end
    mem16[16'h64] = 8'h1F; mem16[16'h74] = 8'h0F;
    for (int i = 0; i < 9; i++) mem16[16'h90 + i] = 8'hFF;
    mem16[16'h99] = 8'h01;
    mem5[30] = 8'h81; mem5[31] = 8'h81; mem5[0] = 8'h01;

    test_reset();
    test_basic();
    test_errors();
    test_full_length();
    test_wrap();
    test_abort();
    test_ignore_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
